// File: rtl/cnn_ctrl_pkg.sv
// Shared types and layer constants for the CNN buffer controllers.
package cnn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        LOADED = 2'd2,
        READ   = 2'd3
    } sched_state_e;

    localparam int unsigned L7_WEIGHT_NUM = 400;
    localparam int unsigned L7_LANES      = 8;
    localparam int unsigned L7_READ_WORDS = 25;
    localparam int unsigned L7_ADDR_W     = 16;

endpackage

// File: rtl/counter_cnn.sv
// Generic up-counter: clear has priority, keep holds, otherwise increment.
module counter_cnn #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         keep,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!keep) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/layer7_weight_sched.sv
// Layer-7 weight buffer controller: streams a weight set into the buffer,
// then sequences word reads for the MAC engine with a per-word handshake.
module layer7_weight_sched
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned WEIGHT_NUM = L7_WEIGHT_NUM,
    parameter int unsigned LANES      = L7_LANES,
    parameter int unsigned READ_WORDS = L7_READ_WORDS,
    parameter int unsigned ADDR_W     = L7_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    output logic              write_weight_signal,
    output logic [15:0]       write_weight_data,
    output logic [ADDR_W-1:0] write_weight_addr,
    output logic              load_done,
    input  logic              compute_start,
    input  logic              compute_next,
    output logic              read_weight_signal,
    output logic [ADDR_W-1:0] read_weight_addr1,
    output logic [ADDR_W-1:0] read_weight_addr2,
    output logic              weight_valid,
    output logic              compute_done,
    output logic              busy,
    output logic              err_early_start
);

    if ((WEIGHT_NUM % LANES) != 0) begin : g_bad_cfg
        $error("WEIGHT_NUM must be a multiple of LANES");
    end

    sched_state_e      state, state_d;
    logic [ADDR_W-1:0] wcnt, ridx;
    logic              wclr, rclr, rstep;
    logic              hs, accept, wcnt_last, ridx_last;
    logic              in_ready_d, ws_d, load_done_d, rsig_d, wv_d, done_d, busy_d, err_d;
    logic [15:0]       wd_d;
    logic [ADDR_W-1:0] wa_d;

    assign hs        = (state == LOAD) && in_valid && in_ready;
    assign accept    = (state == READ) && weight_valid && compute_next;
    assign wcnt_last = (wcnt == ADDR_W'(WEIGHT_NUM - 1));
    assign ridx_last = (ridx == ADDR_W'(READ_WORDS - 1));

    // Word address goes to both ports; the buffer offsets port 2 by itself.
    assign read_weight_addr1 = ridx;
    assign read_weight_addr2 = ridx;

    counter_cnn #(.W(ADDR_W)) u_wcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (wclr),
        .keep (!hs),
        .cnt  (wcnt)
    );

    counter_cnn #(.W(ADDR_W)) u_ridx (
        .clk  (clk),
        .rst  (rst),
        .clr  (rclr),
        .keep (!rstep),
        .cnt  (ridx)
    );

    always_comb begin
        state_d    = state;
        in_ready_d = 1'b0;
        ws_d       = hs;
        wd_d       = hs ? in_data : write_weight_data;
        wa_d       = hs ? wcnt : write_weight_addr;
        rsig_d     = 1'b0;
        wv_d       = 1'b0;
        done_d     = 1'b0;
        wclr       = 1'b0;
        rclr       = 1'b0;
        rstep      = 1'b0;
        err_d      = err_early_start
                   | (compute_start && ((state == IDLE) || (state == LOAD)));

        case (state)
            IDLE: begin
                if (load_start) begin
                    state_d    = LOAD;
                    wclr       = 1'b1;
                    in_ready_d = 1'b1;
                end
            end
            LOAD: begin
                // wcnt reaches WEIGHT_NUM in the cycle carrying the last write
                if (wcnt == ADDR_W'(WEIGHT_NUM)) begin
                    state_d = LOADED;
                end else begin
                    in_ready_d = !(hs && wcnt_last);
                end
            end
            LOADED: begin
                if (compute_start) begin
                    state_d = READ;
                    rclr    = 1'b1;
                    rsig_d  = 1'b1;
                end else if (load_start) begin
                    state_d    = LOAD;
                    wclr       = 1'b1;
                    in_ready_d = 1'b1;
                end
            end
            READ: begin
                rsig_d = 1'b1;
                wv_d   = 1'b1;
                if (accept) begin
                    wv_d = 1'b0;
                    if (ridx_last) begin
                        state_d = LOADED;
                        rsig_d  = 1'b0;
                        done_d  = 1'b1;
                        rclr    = 1'b1;
                    end else begin
                        rstep = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        load_done_d = (state_d == LOADED) || (state_d == READ);
        busy_d      = (state_d == LOAD) || (state_d == READ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            in_ready            <= 1'b0;
            write_weight_signal <= 1'b0;
            write_weight_data   <= '0;
            write_weight_addr   <= '0;
            load_done           <= 1'b0;
            read_weight_signal  <= 1'b0;
            weight_valid        <= 1'b0;
            compute_done        <= 1'b0;
            busy                <= 1'b0;
            err_early_start     <= 1'b0;
        end else begin
            state               <= state_d;
            in_ready            <= in_ready_d;
            write_weight_signal <= ws_d;
            write_weight_data   <= wd_d;
            write_weight_addr   <= wa_d;
            load_done           <= load_done_d;
            read_weight_signal  <= rsig_d;
            weight_valid        <= wv_d;
            compute_done        <= done_d;
            busy                <= busy_d;
            err_early_start     <= err_d;
        end
    end

endmodule

// File: doc/layer7_weight_sched.md
Name: layer7_weight_sched

Overview:
Controller for the layer-7 local weight buffer: a 50-word x 128-bit store, 8 x 16-bit lanes per word, two-port, with a lane-sequencing write side.
- Load phase: accepts a valid/ready stream of 16-bit weights from the bus/DMA side and drives the buffer's write port, one weight per cycle.
- Read phase: sequences word addresses to both read ports for the layer-7 MAC engine, with a per-word consume handshake.
- Sits between the system bus DMA and the layer-7 compute datapath; owns all buffer control signals.

Parameters:
- WEIGHT_NUM, 400, total 16-bit weights per load; must be a multiple of LANES.
- LANES, 8, weights packed per buffer word.
- READ_WORDS, 25, words per read pass. The buffer applies the +25 bank offset on port 2 internally.
- ADDR_W, 16, width of all address outputs.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- load_start  in  1  pulse; begin a weight load.
- in_valid  in  1  weight stream valid.
- in_data  in  16  weight value.
- in_ready  out  1  controller accepts in_data.
- write_weight_signal  out  1  buffer write strobe.
- write_weight_data  out  16  weight to buffer.
- write_weight_addr  out  ADDR_W  element index of the weight being written.
- load_done  out  1  level; complete weight set resident.
- compute_start  in  1  pulse; begin a read pass.
- compute_next  in  1  consumer has taken the current word.
- read_weight_signal  out  1  buffer read enable.
- read_weight_addr1  out  ADDR_W  port-1 word address.
- read_weight_addr2  out  ADDR_W  port-2 word address.
- weight_valid  out  1  buffer outputs hold the word at the current address.
- compute_done  out  1  one-cycle pulse; pass complete.
- busy  out  1  state is LOAD or READ.
- err_early_start  out  1  sticky; compute_start arrived while no weights were resident.

Behaviour:
Reset (rst=0, asynchronous):
- State goes to IDLE; all counters cleared.
- All outputs 0: in_ready, write_weight_signal, write_weight_data, write_weight_addr, load_done, read_weight_signal, both read addresses, weight_valid, compute_done, busy, err_early_start.
- Reset mid-load or mid-read aborts; load_done=0 afterwards. The buffer is reset on the same event, so its lane sequencer restarts at lane 0.

State machine (IDLE, LOAD, LOADED, READ):
- IDLE:
  - load_start -> LOAD; wcnt=0; load_done cleared.
  - compute_start is ignored and sets err_early_start.
- LOAD:
  - in_ready=1 while wcnt<WEIGHT_NUM.
  - On each handshake (in_valid && in_ready), the next cycle drives write_weight_signal=1, write_weight_data=in_data, write_weight_addr=wcnt. wcnt then increments. Write outputs are registered with 1-cycle latency.
  - No handshake means write_weight_signal=0 next cycle, so stalls are allowed.
  - On the WEIGHT_NUM-th handshake: in_ready drops the following cycle; that cycle carries the last write; state goes to LOADED; load_done=1 the cycle after the last write strobe.
  - load_start and compute_start are ignored in LOAD. compute_start in LOAD also sets err_early_start.
- LOADED:
  - compute_start -> READ; ridx=0.
  - load_start -> LOAD; load_done cleared; reload begins.
  - If both arrive in the same cycle, compute_start wins and load_start is dropped.
- READ:
  - read_weight_signal=1; read_weight_addr1=read_weight_addr2=ridx.
  - weight_valid=0 in the first cycle after any address change (buffer latency), then 1.
  - When weight_valid && compute_next:
    - If ridx<READ_WORDS-1: ridx increments; weight_valid=0 next cycle.
    - If ridx==READ_WORDS-1: compute_done pulses 1 cycle; state -> LOADED; read_weight_signal and the addresses return to 0. Weights are retained, so a pass is repeatable without reload.
  - compute_next while weight_valid=0 is ignored.
  - load_start in READ is ignored.

Counter widths:
- wcnt is ADDR_W wide and never exceeds WEIGHT_NUM.
- ridx is ADDR_W wide and never exceeds READ_WORDS-1; no wrap beyond it.

Decomposition:
- Shared package cnn_ctrl_pkg holds:
  - the state enum type (IDLE, LOAD, LOADED, READ);
  - layer-7 constants L7_WEIGHT_NUM=400, L7_LANES=8, L7_READ_WORDS=25.
- Reuse the existing counter_cnn sub-module for both wcnt and ridx, driving its clear/keep controls.
- No other sub-modules.

Test Plan:
1. Reset, then load_start, then 400 back-to-back in_valid with data=index.
   - 400 write strobes; write_weight_addr runs 0..399.
   - load_done=1 exactly one cycle after strobe 399; in_ready=0 from then on.
2. Same load with in_valid low on every third cycle.
   - write strobes have matching gaps; still exactly 400 writes; data order preserved.
3. compute_start after a load, with compute_next held high.
   - Addresses run 0..24.
   - weight_valid alternates 0,1 per word.
   - compute_done pulses after the word-24 accept, 50 cycles after start.
   - State returns to LOADED.
4. compute_start in IDLE, then again during LOAD.
   - Ignored; err_early_start=1 and stays set.
   - In the LOADED state, compute_start still works.
5. rst=0 asserted asynchronously at write 200.
   - All outputs 0 immediately; load_done=0.
   - A fresh load after reset completes with 400 writes.
6. In LOADED, load_start and compute_start in the same cycle.
   - READ entered; no reload occurs; load_done stays 1.
